decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised ID/EX stage of the 5-stage pipeline.
- Owns the architectural register file, with write-through bypass from WB.
- Registers the decoded control bundle, operands, immediate and PC values into EX.
- Adds what the first-generation decode stage lacked: valid tracking, load-use stall detection with bubble insertion, downstream stall/flush handling, and operand refresh while held.

Parameters:
- XLEN, 19, data/register width.
- INSTR_W, 17, instruction width; fields are opcode[4:0], rd[8:5], rs1[12:9], rs2[16:13].
- PC_W, 12, program counter width.
- REG_ADDR_W, 4, register index width.
- NUM_REGS, 16, register count (≤ 2**REG_ADDR_W).
- CTRL_W, 10, control bundle width (layout in decode_pkg).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- instr_d  in  INSTR_W  instruction in D.
- valid_d  in  1  instr_d is real (0 = bubble).
- pc_d, pc_plus1_d  in  PC_W  PC and PC+1 of D instruction.
- ctrl_d  in  CTRL_W  control-unit bundle for instr_d.
- imm_d  in  XLEN  extended immediate for instr_d.
- reg_write_w  in  1  WB write enable.
- rd_w  in  REG_ADDR_W  WB destination.
- result_w  in  XLEN  WB data.
- stall_ext_i  in  1  EX cannot accept; hold E register.
- flush_e_i  in  1  taken branch/jump; kill instruction entering E.
- ctrl_e  out  CTRL_W  registered control bundle.
- rd1_e, rd2_e, imm_e  out  XLEN  registered operands/immediate.
- pc_e, pc_plus1_e  out  PC_W  registered PCs.
- rd_e, rs1_e, rs2_e  out  REG_ADDR_W  registered indices (for the forwarding unit).
- valid_e  out  1  E holds a real instruction.
- rs1_d, rs2_d  out  REG_ADDR_W  combinational D source indices.
- stall_d_o  out  1  F/D must hold this cycle.

Behaviour:
- Reset (async, active-low):
  - All E outputs are 0 and valid_e = 0.
  - All registers are 0.
  - Reset mid-operation discards the in-flight E instruction immediately, without waiting for a clock edge.
- Register file:
  - Write at posedge when reg_write_w and rd_w != 0.
  - R0 always reads 0; writes to R0 are ignored.
- Read path:
  - Combinational read of rs1_d and rs2_d.
  - Bypass: if reg_write_w && rd_w == rsX && rsX != 0, the read returns result_w.
- Latency: D→E is one cycle.
- Load-use detection (combinational): load_use = valid_e && ctrl_e.result_src == RESULTSRC_MEM && rd_e != 0 && valid_d && (rd_e == rs1_d || rd_e == rs2_d).
- stall_d_o = (load_use | stall_ext_i) & ~flush_e_i.
- E register update per posedge, first match wins:
  1. flush_e_i: load bubble (valid_e = 0, ctrl_e = 0, all data fields 0).
  2. stall_ext_i: hold all fields (operand refresh below still applies).
  3. load_use, or valid_d = 0: load bubble.
  4. Otherwise: load D values with valid_e = 1.
- Operand refresh while held:
  - If reg_write_w && rd_w != 0 && rd_w == rs1_e, rd1_e <= result_w.
  - Same rule for rs2_e / rd2_e.
  - This prevents a stale operand after a multi-cycle hold.
- No combinational path from any E output back to the inputs except through stall_d_o.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, adds two outputs, stall_cnt_o and bubble_cnt_o, each 32-bit.
  - stall_cnt_o counts cycles with load_use = 1.
  - bubble_cnt_o counts cycles where a bubble is loaded (flush, load_use, or valid_d = 0).
  - Both counters saturate at all-ones and reset to 0.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- decode_pkg holds:
  - CTRL bit indices: REGWRITE = 0, MEMWRITE = 1, JUMP = 2, BRANCH = 3, ALUSRC = 4, RESULTSRC = 6:5, ALUCTRL = 9:7.
  - RESULTSRC_ALU = 2'b00, RESULTSRC_MEM = 2'b01, RESULTSRC_PC1 = 2'b10.
  - Instruction field offsets.
  - A packed struct for the E register.
- Sub-module decode_regfile: NUM_REGS x XLEN storage, two read ports with bypass, one write port, R0 hardwired to zero.

Test Plan:
- Reset mid-run: valid_e = 1, ctrl_e = 0x07F, then drop reset between clock edges → all E outputs read 0 within the same cycle, with no clock edge.
- Bypass: reg_write_w = 1, rd_w = 3, result_w = 0x01234, instr_d with rs1 = 3 → next cycle rd1_e = 0x01234 and valid_e = 1.
- Load-use: E holds a load (result_src = 01) with rd_e = 5; D has rs2 = 5.
  - stall_d_o = 1 in the same cycle.
  - Next cycle valid_e = 0 and ctrl_e = 0.
  - The cycle after, the D instruction is in E with valid_e = 1.
- Flush beats stall: flush_e_i = 1 with stall_ext_i = 1 → stall_d_o = 0 and next cycle valid_e = 0.
- R0: write R0 = 0x7FFFF, then read rs1 = 0 → rd1_e = 0.
- Hold refresh: stall_ext_i held 3 cycles with rs1_e = 4; WB writes R4 = 0x00ABC during the hold → rd1_e = 0x00ABC, all other E fields unchanged.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the ID/EX decode stage: control-bundle layout,
// instruction field offsets and the E pipeline register type.
package decode_pkg;

  localparam int DEF_XLEN       = 19;
  localparam int DEF_INSTR_W    = 17;
  localparam int DEF_PC_W       = 12;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_NUM_REGS   = 16;
  localparam int DEF_CTRL_W     = 10;

  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_MEMWRITE     = 1;
  localparam int CTRL_JUMP         = 2;
  localparam int CTRL_BRANCH       = 3;
  localparam int CTRL_ALUSRC       = 4;
  localparam int CTRL_RESULTSRC_LO = 5;
  localparam int CTRL_RESULTSRC_HI = 6;
  localparam int CTRL_ALUCTRL_LO   = 7;
  localparam int CTRL_ALUCTRL_HI   = 9;

  typedef enum logic [1:0] {
    RESULTSRC_ALU = 2'b00,
    RESULTSRC_MEM = 2'b01,
    RESULTSRC_PC1 = 2'b10
  } resultSrcT;

  localparam int OPCODE_LO = 0;
  localparam int OPCODE_HI = 4;
  localparam int RD_LO     = 5;
  localparam int RD_HI     = 8;
  localparam int RS1_LO    = 9;
  localparam int RS1_HI    = 12;
  localparam int RS2_LO    = 13;
  localparam int RS2_HI    = 16;

  // An all-zero value of this struct is exactly a pipeline bubble.
  typedef struct packed {
    logic                      valid;
    logic [DEF_CTRL_W-1:0]     ctrl;
    logic [DEF_XLEN-1:0]       rd1;
    logic [DEF_XLEN-1:0]       rd2;
    logic [DEF_XLEN-1:0]       imm;
    logic [DEF_PC_W-1:0]       pc;
    logic [DEF_PC_W-1:0]       pcPlus1;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic [DEF_REG_ADDR_W-1:0] rs1;
    logic [DEF_REG_ADDR_W-1:0] rs2;
  } eRegT;

  function automatic logic isLoad(input logic [DEF_CTRL_W-1:0] ctrl);
    return resultSrcT'(ctrl[CTRL_RESULTSRC_HI:CTRL_RESULTSRC_LO]) == RESULTSRC_MEM;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two combinational read ports with
// write-through bypass from WB, one write port, R0 hardwired to zero.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]       wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Writes to R0 are dropped so that entry never leaves its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0 && 32'(wa) < NUM_REGS) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (we && wa == ra1)            rd1 = wd;
      else if (32'(ra1) < NUM_REGS)   rd1 = regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (we && wa == ra2)            rd2 = wd;
      else if (32'(ra2) < NUM_REGS)   rd2 = regs[ra2];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID/EX stage: register file read, load-use/stall/flush control and the E register.
// Optional DECODE_PERF_CNT_EN adds saturating stall and bubble counters.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int CTRL_W     = DEF_CTRL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    instr_d,
  input  logic                  valid_d,
  input  logic [PC_W-1:0]       pc_d,
  input  logic [PC_W-1:0]       pc_plus1_d,
  input  logic [CTRL_W-1:0]     ctrl_d,
  input  logic [XLEN-1:0]       imm_d,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic [XLEN-1:0]       result_w,
  input  logic                  stall_ext_i,
  input  logic                  flush_e_i,
  output logic [CTRL_W-1:0]     ctrl_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_e,
  output logic [PC_W-1:0]       pc_e,
  output logic [PC_W-1:0]       pc_plus1_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic                  valid_e,
  output logic [REG_ADDR_W-1:0] rs1_d,
  output logic [REG_ADDR_W-1:0] rs2_d,
  output logic                  stall_d_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           bubble_cnt_o
`endif
);

  logic [REG_ADDR_W-1:0] rdD;
  logic [XLEN-1:0]       rfRd1;
  logic [XLEN-1:0]       rfRd2;
  logic                  loadUse;
  logic                  bubbleLoad;
  logic                  unusedOpcode;
  eRegT                  eReg;
  eRegT                  heldE;
  eRegT                  loadedE;

  assign rdD          = instr_d[RD_HI:RD_LO];
  assign rs1_d        = instr_d[RS1_HI:RS1_LO];
  assign rs2_d        = instr_d[RS2_HI:RS2_LO];
  assign unusedOpcode = ^instr_d[OPCODE_HI:OPCODE_LO];

  decode_regfile #(
    .XLEN       (XLEN),
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) regFile (
    .clk   (clk),
    .reset (reset),
    .we    (reg_write_w),
    .wa    (rd_w),
    .wd    (result_w),
    .ra1   (rs1_d),
    .ra2   (rs2_d),
    .rd1   (rfRd1),
    .rd2   (rfRd2)
  );

  // A load in E whose destination feeds D cannot be forwarded in time.
  assign loadUse = eReg.valid && isLoad(eReg.ctrl) && eReg.rd != '0 && valid_d
                   && (eReg.rd == rs1_d || eReg.rd == rs2_d);

  assign stall_d_o  = (loadUse | stall_ext_i) & ~flush_e_i;
  assign bubbleLoad = flush_e_i | (~stall_ext_i & (loadUse | ~valid_d));

  // Held operands track WB writes so a long hold never leaves them stale.
  always_comb begin
    heldE = eReg;
    if (reg_write_w && rd_w != '0 && rd_w == eReg.rs1) heldE.rd1 = result_w;
    if (reg_write_w && rd_w != '0 && rd_w == eReg.rs2) heldE.rd2 = result_w;
  end

  always_comb begin
    loadedE         = '0;
    loadedE.valid   = 1'b1;
    loadedE.ctrl    = ctrl_d;
    loadedE.rd1     = rfRd1;
    loadedE.rd2     = rfRd2;
    loadedE.imm     = imm_d;
    loadedE.pc      = pc_d;
    loadedE.pcPlus1 = pc_plus1_d;
    loadedE.rd      = rdD;
    loadedE.rs1     = rs1_d;
    loadedE.rs2     = rs2_d;
  end

  // Priority: flush, then external stall, then bubble on hazard/empty D.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     eReg <= '0;
    else if (flush_e_i)             eReg <= '0;
    else if (stall_ext_i)           eReg <= heldE;
    else if (loadUse || !valid_d)   eReg <= '0;
    else                            eReg <= loadedE;
  end

  assign valid_e    = eReg.valid;
  assign ctrl_e     = eReg.ctrl;
  assign rd1_e      = eReg.rd1;
  assign rd2_e      = eReg.rd2;
  assign imm_e      = eReg.imm;
  assign pc_e       = eReg.pc;
  assign pc_plus1_e = eReg.pcPlus1;
  assign rd_e       = eReg.rd;
  assign rs1_e      = eReg.rs1;
  assign rs2_e      = eReg.rs2;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] bubbleCnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (loadUse && stallCnt != '1)      stallCnt  <= stallCnt + 32'd1;
      if (bubbleLoad && bubbleCnt != '1)  bubbleCnt <= bubbleCnt + 32'd1;
    end
  end

  assign stall_cnt_o  = stallCnt;
  assign bubble_cnt_o = bubbleCnt;
`else
  logic unusedBubble;
  assign unusedBubble = bubbleLoad;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scoreboard bench for decode_stage_pipe: expected E contents are
// queued when D is driven and compared one cycle later.
module tb_decode_stage_pipe;

  logic        clk;
  logic        reset;
  logic [16:0] instr_d;
  logic        valid_d;
  logic [11:0] pc_d;
  logic [11:0] pc_plus1_d;
  logic [9:0]  ctrl_d;
  logic [18:0] imm_d;
  logic        reg_write_w;
  logic [3:0]  rd_w;
  logic [18:0] result_w;
  logic        stall_ext_i;
  logic        flush_e_i;
  logic [9:0]  ctrl_e;
  logic [18:0] rd1_e;
  logic [18:0] rd2_e;
  logic [18:0] imm_e;
  logic [11:0] pc_e;
  logic [11:0] pc_plus1_e;
  logic [3:0]  rd_e;
  logic [3:0]  rs1_e;
  logic [3:0]  rs2_e;
  logic        valid_e;
  logic [3:0]  rs1_d;
  logic [3:0]  rs2_d;
  logic        stall_d_o;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic [18:0] rd1;
    logic [18:0] rd2;
    logic [18:0] imm;
    logic [11:0] pc;
    logic [11:0] pcp1;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } eViewT;

  eViewT expQ[$];
  eViewT expHeld;
  int    checks = 0;
  int    errors = 0;

  decode_stage_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .instr_d     (instr_d),
    .valid_d     (valid_d),
    .pc_d        (pc_d),
    .pc_plus1_d  (pc_plus1_d),
    .ctrl_d      (ctrl_d),
    .imm_d       (imm_d),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .result_w    (result_w),
    .stall_ext_i (stall_ext_i),
    .flush_e_i   (flush_e_i),
    .ctrl_e      (ctrl_e),
    .rd1_e       (rd1_e),
    .rd2_e       (rd2_e),
    .imm_e       (imm_e),
    .pc_e        (pc_e),
    .pc_plus1_e  (pc_plus1_e),
    .rd_e        (rd_e),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .valid_e     (valid_e),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .stall_d_o   (stall_d_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic eViewT observedE();
    eViewT v;
    v = '{valid: valid_e, ctrl: ctrl_e, rd1: rd1_e, rd2: rd2_e, imm: imm_e,
          pc: pc_e, pcp1: pc_plus1_e, rd: rd_e, rs1: rs1_e, rs2: rs2_e};
    return v;
  endfunction

  function automatic eViewT mkE(input logic [9:0] ctrl, input logic [18:0] rd1,
                                input logic [18:0] rd2, input logic [18:0] imm,
                                input logic [11:0] pc, input logic [3:0] rd,
                                input logic [3:0] rs1, input logic [3:0] rs2);
    eViewT v;
    v = '{valid: 1'b1, ctrl: ctrl, rd1: rd1, rd2: rd2, imm: imm,
          pc: pc, pcp1: pc + 12'd1, rd: rd, rs1: rs1, rs2: rs2};
    return v;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rd, input logic [3:0] rs1,
                               input logic [3:0] rs2, input logic [9:0] ctrl,
                               input logic [18:0] imm, input logic [11:0] pc);
    valid_d    = v;
    instr_d    = {rs2, rs1, rd, 5'h13};
    ctrl_d     = ctrl;
    imm_d      = imm;
    pc_d       = pc;
    pc_plus1_d = pc + 12'd1;
  endtask

  task automatic setWb(input logic we, input logic [3:0] rd, input logic [18:0] val);
    reg_write_w = we;
    rd_w        = rd;
    result_w    = val;
  endtask

  task automatic checkOutput(input string tag);
    eViewT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal(tag, 128'(observedE()), 128'(e));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b0;
    stall_ext_i = 1'b0;
    flush_e_i = 1'b0;
    setWb(1'b0, 4'd0, 19'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 10'd0, 19'd0, 12'd0);
    #2;
    checkVal("resetE", 128'(observedE()), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Preload R4, R2 and attempt a write to R0 while D carries bubbles.
    setWb(1'b1, 4'd4, 19'h00111);
    expQ.push_back('0);
    tick("bubbleWr4");
    setWb(1'b1, 4'd2, 19'h00222);
    expQ.push_back('0);
    tick("bubbleWr2");
    setWb(1'b1, 4'd0, 19'h7FFFF);
    expQ.push_back('0);
    tick("bubbleWr0");

    // R0 reads as zero regardless of the earlier write.
    setWb(1'b0, 4'd0, 19'd0);
    applyStimulus(1'b1, 4'd1, 4'd0, 4'd2, 10'h081, 19'h00005, 12'h010);
    #1;
    checkVal("rs1dComb", 128'(rs1_d), 128'd0);
    checkVal("rs2dComb", 128'(rs2_d), 128'd2);
    checkVal("noStall", 128'(stall_d_o), 128'd0);
    expQ.push_back(mkE(10'h081, 19'd0, 19'h00222, 19'h00005, 12'h010, 4'd1, 4'd0, 4'd2));
    tick("r0Read");

    // Same-cycle WB bypass into rs1.
    setWb(1'b1, 4'd3, 19'h01234);
    applyStimulus(1'b1, 4'd6, 4'd3, 4'd4, 10'h001, 19'h00007, 12'h011);
    expQ.push_back(mkE(10'h001, 19'h01234, 19'h00111, 19'h00007, 12'h011, 4'd6, 4'd3, 4'd4));
    tick("bypass");

    // Load to R5 enters E.
    setWb(1'b0, 4'd0, 19'd0);
    applyStimulus(1'b1, 4'd5, 4'd2, 4'd0, 10'h021, 19'h00010, 12'h012);
    expQ.push_back(mkE(10'h021, 19'h00222, 19'd0, 19'h00010, 12'h012, 4'd5, 4'd2, 4'd0));
    tick("loadInE");

    // Consumer of R5 in D: stall now, bubble next, then consumer advances.
    applyStimulus(1'b1, 4'd7, 4'd4, 4'd5, 10'h001, 19'h00020, 12'h013);
    #1;
    checkVal("loadUseStall", 128'(stall_d_o), 128'd1);
    expQ.push_back('0);
    tick("loadUseBubble");
    checkVal("stallCleared", 128'(stall_d_o), 128'd0);
    expHeld = mkE(10'h001, 19'h00111, 19'd0, 19'h00020, 12'h013, 4'd7, 4'd4, 4'd5);
    expQ.push_back(expHeld);
    tick("consumerInE");

    // Three-cycle external hold; R4 rewritten during the second cycle.
    stall_ext_i = 1'b1;
    applyStimulus(1'b1, 4'd8, 4'd1, 4'd1, 10'h011, 19'h00030, 12'h014);
    #1;
    checkVal("extStall", 128'(stall_d_o), 128'd1);
    expQ.push_back(expHeld);
    tick("hold1");
    setWb(1'b1, 4'd4, 19'h00ABC);
    expHeld.rd1 = 19'h00ABC;
    expQ.push_back(expHeld);
    tick("hold2Refresh");
    setWb(1'b0, 4'd0, 19'd0);
    expQ.push_back(expHeld);
    tick("hold3");

    // Release: new instruction reads the updated R4.
    stall_ext_i = 1'b0;
    applyStimulus(1'b1, 4'd8, 4'd4, 4'd2, 10'h011, 19'h00030, 12'h014);
    expQ.push_back(mkE(10'h011, 19'h00ABC, 19'h00222, 19'h00030, 12'h014, 4'd8, 4'd4, 4'd2));
    tick("afterHold");

    // Flush takes priority over an external stall.
    stall_ext_i = 1'b1;
    flush_e_i = 1'b1;
    applyStimulus(1'b1, 4'd9, 4'd2, 4'd3, 10'h001, 19'h00040, 12'h020);
    #1;
    checkVal("flushNoStall", 128'(stall_d_o), 128'd0);
    expQ.push_back('0);
    tick("flushBubble");
    stall_ext_i = 1'b0;
    flush_e_i = 1'b0;

    // Asynchronous reset between edges clears a live E instruction.
    applyStimulus(1'b1, 4'd9, 4'd2, 4'd3, 10'h07F, 19'h00050, 12'h021);
    expQ.push_back(mkE(10'h07F, 19'h00222, 19'h01234, 19'h00050, 12'h021, 4'd9, 4'd2, 4'd3));
    tick("preReset");
    #2;
    reset = 1'b0;
    #1;
    checkVal("asyncResetE", 128'(observedE()), 128'd0);
    checkVal("asyncResetValid", 128'(valid_e), 128'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
